// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add multiplier sequencer borrowing the shared ALU adder
// Optional feature: define ALU_MUL_ZERO_SKIP_EN to finish zero-operand multiplies in one edge.
module alu_mul_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [W-1:0]     MultA,
    input  logic [W-1:0]     MultB,
    output logic             Busy,
    output logic             Done,
    output logic [2*W-1:0]   Product,
    output logic             AluReq,
    input  logic             AluGnt,
    output logic [W-1:0]     AluInA,
    output logic [W-1:0]     AluInB,
    output logic [3:0]       AluOp,
    input  logic [W-1:0]     AluOut,
    input  logic             AluCarry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [W-1:0]       m;
    logic [W-1:0]       p_hi;
    logic [W-1:0]       q;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     product_r;

    logic [W-1:0]       p_sh;
    logic [W-1:0]       q_sh;
    logic               zero_op;

    // One-bit right shift of the 2W+1 bit accumulator {C, P_hi, Q}
    assign p_sh = {c, p_hi[W-1:1]};
    assign q_sh = {p_hi[0], q[W-1:1]};

`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zero_op = (MultA == '0) || (MultB == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            m         <= '0;
            p_hi      <= '0;
            q         <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        m    <= MultA;
                        q    <= MultB;
                        p_hi <= '0;
                        c    <= 1'b0;
                        cnt  <= '0;
                        if (zero_op) begin
                            product_r <= '0;
                            state     <= S_DONE;
                        end else begin
                            state <= MultB[0] ? S_ADD : S_SHIFT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    // Without a grant the ALU result is not ours; hold everything
                    if (AluGnt) begin
                        p_hi  <= AluOut;
                        c     <= AluCarry;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    p_hi <= p_sh;
                    q    <= q_sh;
                    c    <= 1'b0;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) begin
                        product_r <= {p_sh, q_sh};
                        state     <= S_DONE;
                    end else begin
                        state <= q_sh[0] ? S_ADD : S_SHIFT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy    = (state == S_ADD) || (state == S_SHIFT);
    assign Done    = (state == S_DONE);
    assign AluReq  = (state == S_ADD);
    assign AluInA  = (state == S_ADD) ? p_hi : '0;
    assign AluInB  = (state == S_ADD) ? m : '0;
    assign AluOp   = 4'b0000;
    assign Product = product_r;

endmodule
